// File: rtl/reg_write_queue.sv
// In-order writeback queue feeding the register-file write port.
// Requests are buffered in a small FIFO, and a combinational query forwards the youngest pending value.
module reg_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          reg_wq_clk,
    input  logic          reg_wq_rst,
    input  logic          reg_wq_in_valid,
    output logic          reg_wq_in_ready,
    input  logic [4:0]    reg_wq_in_id,
    input  logic [31:0]   reg_wq_in_data,
    input  logic          reg_wq_stall,
    output logic          reg_wq_write_sig,
    output logic [4:0]    reg_wq_write_id,
    output logic [31:0]   reg_wq_write_data,
    input  logic [4:0]    reg_wq_query_id,
    output logic          reg_wq_query_hit,
    output logic [31:0]   reg_wq_query_data,
    output logic [AW:0]   reg_wq_count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [4:0]    r_ids  [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_rdPtr;
    logic [AW-1:0] r_wrPtr;
    logic [AW:0]   r_count;
    logic          r_writeSig;
    logic [4:0]    r_writeId;
    logic [31:0]   r_writeData;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_idx;
    logic          w_hit;
    logic [31:0]   w_qData;

    // Ready looks only at the current count, so a full queue refuses input even while it dequeues.
    assign reg_wq_in_ready = !reg_wq_rst && (r_count != FULL_COUNT);
    assign w_accept        = reg_wq_in_valid && reg_wq_in_ready;
    assign w_push          = w_accept && (reg_wq_in_id != 5'd0);
    assign w_pop           = !reg_wq_stall && (r_count != '0);

    always_ff @(posedge reg_wq_clk) begin
        if (w_push) begin
            r_ids[r_wrPtr]  <= reg_wq_in_id;
            r_data[r_wrPtr] <= reg_wq_in_data;
        end
    end

    always_ff @(posedge reg_wq_clk) begin
        if (reg_wq_rst) begin
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
            r_count     <= '0;
            r_writeSig  <= 1'b0;
            r_writeId   <= 5'd0;
            r_writeData <= 32'd0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_writeSig  <= 1'b1;
                r_writeId   <= r_ids[r_rdPtr];
                r_writeData <= r_data[r_rdPtr];
                r_rdPtr     <= r_rdPtr + 1'b1;
            end else begin
                r_writeSig  <= 1'b0;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Scan oldest to youngest so later matches overwrite earlier ones; the output register is oldest of all.
    always_comb begin
        w_hit   = 1'b0;
        w_qData = 32'd0;
        w_idx   = '0;
        if (reg_wq_query_id != 5'd0) begin
            if (r_writeSig && (r_writeId == reg_wq_query_id)) begin
                w_hit   = 1'b1;
                w_qData = r_writeData;
            end
            for (int i = 0; i < DEPTH; i++) begin
                w_idx = r_rdPtr + AW'(i);
                if (((AW+1)'(i) < r_count) && (r_ids[w_idx] == reg_wq_query_id)) begin
                    w_hit   = 1'b1;
                    w_qData = r_data[w_idx];
                end
            end
        end
    end

    assign reg_wq_write_sig  = r_writeSig;
    assign reg_wq_write_id   = r_writeId;
    assign reg_wq_write_data = r_writeData;
    assign reg_wq_query_hit  = w_hit;
    assign reg_wq_query_data = w_qData;
    assign reg_wq_count      = r_count;

endmodule

// File: tb/tb_reg_write_queue.sv
// Directed bench for reg_write_queue: a vector table for the main flows plus
// hand-written wrap-around and mid-operation reset sequences.
module tb_reg_write_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [4:0]  inId;
    logic [31:0] inData;
    logic        stall;
    logic        writeSig;
    logic [4:0]  writeId;
    logic [31:0] writeData;
    logic [4:0]  queryId;
    logic        queryHit;
    logic [31:0] queryData;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        valid;
        logic [4:0]  id;
        logic [31:0] data;
        logic        stall;
        logic [4:0]  qid;
        logic        eSig;
        logic [4:0]  eId;
        logic [31:0] eData;
        logic [2:0]  eCnt;
        logic        eRdy;
        logic        eHit;
        logic [31:0] eQData;
    } vec_t;

    vec_t vecs [25];

    reg_write_queue #(.DEPTH(4), .AW(2)) dut (
        .reg_wq_clk        (clk),
        .reg_wq_rst        (rst),
        .reg_wq_in_valid   (inValid),
        .reg_wq_in_ready   (inReady),
        .reg_wq_in_id      (inId),
        .reg_wq_in_data    (inData),
        .reg_wq_stall      (stall),
        .reg_wq_write_sig  (writeSig),
        .reg_wq_write_id   (writeId),
        .reg_wq_write_data (writeData),
        .reg_wq_query_id   (queryId),
        .reg_wq_query_hit  (queryHit),
        .reg_wq_query_data (queryData),
        .reg_wq_count      (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then let one rising edge pass and settle.
    task automatic applyStimulus(input logic v, input logic [4:0] id, input logic [31:0] d,
                                 input logic s, input logic [4:0] q);
        @(negedge clk);
        inValid = v;
        inId    = id;
        inData  = d;
        stall   = s;
        queryId = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pushed;
        int issued;
        int cyc;
        logic accept;

        rst = 1'b1; inValid = 1'b0; inId = 5'd0; inData = 32'd0; stall = 1'b0; queryId = 5'd0;

        vecs[0]  = '{1'b1, 5'd5,  32'h1234, 1'b0, 5'd5,  1'b0, 5'd0,  32'h0,    3'd1, 1'b1, 1'b1, 32'h1234};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd5,  1'b1, 5'd5,  32'h1234, 3'd0, 1'b1, 1'b1, 32'h1234};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd5,  1'b0, 5'd5,  32'h1234, 3'd0, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFF, 1'b0, 5'd0,  1'b0, 5'd5,  32'h1234, 3'd0, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  1'b0, 5'd5,  32'h1234, 3'd0, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 5'd1,  32'd10,   1'b1, 5'd1,  1'b0, 5'd5,  32'h1234, 3'd1, 1'b1, 1'b1, 32'd10};
        vecs[6]  = '{1'b1, 5'd2,  32'd20,   1'b1, 5'd2,  1'b0, 5'd5,  32'h1234, 3'd2, 1'b1, 1'b1, 32'd20};
        vecs[7]  = '{1'b1, 5'd3,  32'd30,   1'b1, 5'd3,  1'b0, 5'd5,  32'h1234, 3'd3, 1'b1, 1'b1, 32'd30};
        vecs[8]  = '{1'b1, 5'd4,  32'd40,   1'b1, 5'd4,  1'b0, 5'd5,  32'h1234, 3'd4, 1'b0, 1'b1, 32'd40};
        vecs[9]  = '{1'b1, 5'd9,  32'd99,   1'b1, 5'd9,  1'b0, 5'd5,  32'h1234, 3'd4, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd1,  1'b1, 5'd1,  32'd10,   3'd3, 1'b1, 1'b1, 32'd10};
        vecs[11] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd2,  1'b1, 5'd2,  32'd20,   3'd2, 1'b1, 1'b1, 32'd20};
        vecs[12] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd3,  1'b1, 5'd3,  32'd30,   3'd1, 1'b1, 1'b1, 32'd30};
        vecs[13] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd4,  1'b1, 5'd4,  32'd40,   3'd0, 1'b1, 1'b1, 32'd40};
        vecs[14] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd4,  1'b0, 5'd4,  32'd40,   3'd0, 1'b1, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 5'd7,  32'd1,    1'b1, 5'd7,  1'b0, 5'd4,  32'd40,   3'd1, 1'b1, 1'b1, 32'd1};
        vecs[16] = '{1'b1, 5'd7,  32'd2,    1'b1, 5'd7,  1'b0, 5'd4,  32'd40,   3'd2, 1'b1, 1'b1, 32'd2};
        vecs[17] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd7,  1'b1, 5'd7,  32'd1,    3'd1, 1'b1, 1'b1, 32'd2};
        vecs[18] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  1'b0, 5'd7,  32'd1,    3'd1, 1'b1, 1'b1, 32'd2};
        vecs[19] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd7,  1'b1, 5'd7,  32'd2,    3'd0, 1'b1, 1'b1, 32'd2};
        vecs[20] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd7,  1'b0, 5'd7,  32'd2,    3'd0, 1'b1, 1'b0, 32'h0};
        vecs[21] = '{1'b1, 5'd10, 32'd100,  1'b0, 5'd10, 1'b0, 5'd7,  32'd2,    3'd1, 1'b1, 1'b1, 32'd100};
        vecs[22] = '{1'b1, 5'd11, 32'd110,  1'b0, 5'd10, 1'b1, 5'd10, 32'd100,  3'd1, 1'b1, 1'b1, 32'd100};
        vecs[23] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd11, 1'b1, 5'd11, 32'd110,  3'd0, 1'b1, 1'b1, 32'd110};
        vecs[24] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd11, 1'b0, 5'd11, 32'd110,  3'd0, 1'b1, 1'b0, 32'h0};

        // Reset state, with ready held low while reset is asserted.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("reset sig",   32'(writeSig),  32'd0);
        checkOutput("reset id",    32'(writeId),   32'd0);
        checkOutput("reset data",  writeData,      32'd0);
        checkOutput("reset count", 32'(count),     32'd0);
        checkOutput("reset ready", 32'(inReady),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("ready after reset", 32'(inReady), 32'd1);

        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].id, vecs[i].data, vecs[i].stall, vecs[i].qid);
            checkOutput($sformatf("row%0d sig", i),   32'(writeSig),  32'(vecs[i].eSig));
            checkOutput($sformatf("row%0d id", i),    32'(writeId),   32'(vecs[i].eId));
            checkOutput($sformatf("row%0d data", i),  writeData,      vecs[i].eData);
            checkOutput($sformatf("row%0d count", i), 32'(count),     32'(vecs[i].eCnt));
            checkOutput($sformatf("row%0d ready", i), 32'(inReady),   32'(vecs[i].eRdy));
            checkOutput($sformatf("row%0d hit", i),   32'(queryHit),  32'(vecs[i].eHit));
            checkOutput($sformatf("row%0d qdata", i), queryData,      vecs[i].eQData);
        end

        // Wrap-around: ten entries through a four-deep queue with alternating stall.
        pushed = 0;
        issued = 0;
        cyc    = 0;
        while (issued < 10 && cyc < 200) begin
            @(negedge clk);
            inValid = (pushed < 10);
            inId    = 5'(pushed + 1);
            inData  = 32'h100 + 32'(pushed);
            stall   = (cyc % 2 == 1);
            queryId = 5'd0;
            #1;
            accept = inValid && inReady;
            @(posedge clk);
            #1;
            if (accept) pushed++;
            if (writeSig) begin
                checkOutput($sformatf("wrap%0d id", issued),   32'(writeId), 32'(issued + 1));
                checkOutput($sformatf("wrap%0d data", issued), writeData,    32'h100 + 32'(issued));
                issued++;
            end
            cyc++;
        end
        checkOutput("wrap issued", 32'(issued), 32'd10);
        checkOutput("wrap count",  32'(count),  32'd0);

        // Reset mid-operation while a write is pending.
        applyStimulus(1'b1, 5'd20, 32'hA0, 1'b1, 5'd0);
        applyStimulus(1'b1, 5'd21, 32'hA1, 1'b1, 5'd0);
        applyStimulus(1'b1, 5'd22, 32'hA2, 1'b1, 5'd0);
        checkOutput("pre-reset count", 32'(count), 32'd3);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd21);
        checkOutput("pre-reset sig",   32'(writeSig), 32'd1);
        checkOutput("pre-reset id",    32'(writeId),  32'd20);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd21);
        checkOutput("midrst sig",   32'(writeSig), 32'd0);
        checkOutput("midrst id",    32'(writeId),  32'd0);
        checkOutput("midrst data",  writeData,     32'd0);
        checkOutput("midrst count", 32'(count),    32'd0);
        checkOutput("midrst ready", 32'(inReady),  32'd0);
        checkOutput("midrst hit",   32'(queryHit), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd22);
            checkOutput($sformatf("postrst%0d sig", k),   32'(writeSig), 32'd0);
            checkOutput($sformatf("postrst%0d count", k), 32'(count),    32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_write_queue.md
# reg_write_queue

Buffered writer for the MIPS register file write port. Collects writeback requests (register id + 32-bit data) from the execute/memory stages through a valid/ready handshake, holds them in an in-order FIFO and issues at most one register-file write per clock. A combinational query port lets the read side forward the youngest pending value for a register that has not yet been written.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2
- AW, 2, pointer width, log2(DEPTH)

Ports:
- reg_wq_clk  input  1  clock; all state changes on the rising edge
- reg_wq_rst  input  1  reset, synchronous, active-high
- reg_wq_in_valid  input  1  writeback request present
- reg_wq_in_ready  output  1  queue can accept; high when count < DEPTH and reg_wq_rst low
- reg_wq_in_id  input  5  destination register id
- reg_wq_in_data  input  32  value to write
- reg_wq_stall  input  1  holds dequeue; no write issued while high
- reg_wq_write_sig  output  1  register-file write enable, registered
- reg_wq_write_id  output  5  register-file write id, registered
- reg_wq_write_data  output  32  register-file write data, registered
- reg_wq_query_id  input  5  register id to look up
- reg_wq_query_hit  output  1  a pending value for query id exists
- reg_wq_query_data  output  32  youngest pending value for query id; 0 when no hit
- reg_wq_count  output  AW+1  entries currently queued, output register excluded

## Operation
- Storage: DEPTH entries of {id[4:0], data[31:0]}, read pointer, write pointer, count. Pointers are AW bits and wrap modulo DEPTH.
- Enqueue: when in_valid and in_ready at the edge, the request is accepted. If in_id is 0, the request is accepted and discarded: no entry is written and count is unchanged. Register 0 is hardwired zero.
- Dequeue: at each edge where stall is low and count > 0, the head entry is popped into the output register and write_sig is set for the next cycle. Otherwise write_sig is cleared, and write_id and write_data hold their values.
- write_sig is high for exactly one cycle per dequeued entry. Writes issue in strict acceptance order.
- Simultaneous enqueue and dequeue: the count is unchanged and both pointers advance. in_ready is computed from the current count only, so a full queue refuses input even in a cycle when it dequeues.
- Query is combinational. Candidates are the valid FIFO entries plus the output register when write_sig is high. The youngest match wins: the FIFO entry nearest the tail beats older FIFO entries, and any FIFO entry beats the output register.
- Query id 0 always returns hit=0, data=0.
- Reset: both pointers 0, count 0, write_sig 0, write_id 0, write_data 0. Queued entries are discarded. in_ready is 0 while reset is high.
- Reset mid-operation: a pending write_sig is cleared at the reset edge. Stored entries are never issued after reset.

## Timing
- Request accepted at edge N on an empty, unstalled queue: dequeued at edge N+1, write_sig high during cycle N+1..N+2, register file commits at edge N+2. Minimum latency is 2 edges from acceptance to commit.
- There is no bypass from input to output register. An entry must spend at least one cycle in the FIFO.
- Sustained throughput is one write per cycle when unstalled.
- in_ready falls in the cycle after the accepting edge that makes count == DEPTH. It rises in the cycle after the first dequeue from full.
- Stall is sampled at the edge. A stall asserted during a cycle with write_sig high does not cancel that write; it only blocks the next dequeue.
- Query results reflect state after the most recent edge. Entries accepted at the current edge are not visible until after it.

## Test plan
- Single write: reset, then accept id=5 data=0x1234 at edge 1 → write_sig=1, id=5, data=0x1234 during cycle 2 only; count returns to 0.
- Fill and drain: stall=1, accept ids 1,2,3,4 with data 10,20,30,40 → count=4, in_ready=0, fifth request not accepted; release stall → four consecutive writes in order 1,2,3,4, then write_sig=0.
- Zero register: accept id=0 data=0xFFFF → count stays 0, no write_sig; query id 0 → hit=0, data=0.
- Forwarding priority: stall=1, accept id=7 data=1 then id=7 data=2 → query 7 gives hit=1, data=2. Release stall for one cycle so data=1 is in the output register → data still 2. After both commit → hit=0.
- Wrap-around: push and pop 10 entries through DEPTH=4 with alternating stall → all 10 issued in order, with correct data, and no loss at pointer wrap.
- Reset mid-operation: queue 3 entries with stall=1, assert reset for one edge, deassert stall → count=0, write_sig stays 0, nothing issued.
